priv_1_11_trap_ctrl: RTL and testbench

PRIV_1_11_TRAP_CTRL -- requirements
Module: priv_1_11_trap_ctrl

---
 rtl/machine_mode_types_1_11_pkg.sv | 30 +++
 rtl/priv_1_11_irq_sync.sv | 34 +++
 rtl/priv_1_11_trap_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_priv_1_11_trap_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/machine_mode_types_1_11_pkg.sv
// ============================================================================
// Module      : machine_mode_types_1_11_pkg
// Description : Shared types and constants for the machine-mode trap controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package machine_mode_types_1_11_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        RET      = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

    localparam logic [31:0] c_MEI_CODE = 32'd11;
    localparam logic [31:0] c_MSI_CODE = 32'd3;
    localparam logic [31:0] c_MTI_CODE = 32'd7;

    localparam int c_MSTATUS_MIE  = 3;
    localparam int c_MSTATUS_MPIE = 7;

    function automatic logic [31:0] trap_base(input logic [31:0] tvec);
        return {tvec[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/priv_1_11_irq_sync.sv
// ============================================================================
// Module      : priv_1_11_irq_sync
// Description : Multi-flop synchronizer for one raw interrupt line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priv_1_11_irq_sync #(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_irq,
    output logic o_irq_sync
);

    // Fewer than two flops gives no metastability protection
    localparam int c_STAGES = (IRQ_SYNC_STAGES < 2) ? 2 : IRQ_SYNC_STAGES;

    logic [c_STAGES-1:0] r_sync;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_STAGES-2:0], i_irq};
        end
    end

    assign o_irq_sync = r_sync[c_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/priv_1_11_trap_ctrl.sv
// ============================================================================
// Module      : priv_1_11_trap_ctrl
// Description : Machine-mode trap/MRET sequencer; vectored interrupt targets
//               are enabled by defining PRIV_VECTORED_INT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priv_1_11_trap_ctrl
    import machine_mode_types_1_11_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ext_int,
    input  logic        timer_int,
    input  logic        soft_int,
    input  logic        exception,
    input  logic [3:0]  ex_cause,
    input  logic [31:0] commit_pc,
    input  logic [31:0] ex_tval,
    input  logic        mret,
    input  logic        pipe_ready,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        mip_rup,
    output logic        mcause_rup,
    output logic        mepc_rup,
    output logic        mtval_rup,
    output logic        mstatus_rup,
    output logic [31:0] mip_next,
    output logic [31:0] mcause_next,
    output logic [31:0] mepc_next,
    output logic [31:0] mtval_next,
    output logic [31:0] mstatus_next,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    trap_state_t r_state;
    trap_state_t w_state_next;

    logic        r_mip_rup;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic [31:0] r_target;

    logic [2:0]  w_raw_irq;
    logic [2:0]  w_sync_irq;
    logic [31:0] w_mip;
    logic        w_pend_mei;
    logic        w_pend_msi;
    logic        w_pend_mti;
    logic        w_irq_take;
    logic [31:0] w_irq_code;
    logic [31:0] w_irq_target;
    logic        w_unused;

    // Line order: [2]=external, [1]=timer, [0]=software
    assign w_raw_irq = {ext_int, timer_int, soft_int};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_irq_sync
            priv_1_11_irq_sync #(
                .IRQ_SYNC_STAGES(IRQ_SYNC_STAGES)
            ) u_sync (
                .CLK       (CLK),
                .nRST      (nRST),
                .i_irq     (w_raw_irq[g]),
                .o_irq_sync(w_sync_irq[g])
            );
        end
    endgenerate

    always_comb begin
        w_mip     = 32'd0;
        w_mip[11] = w_sync_irq[2];
        w_mip[7]  = w_sync_irq[1];
        w_mip[3]  = w_sync_irq[0];
    end

    assign w_pend_mei = w_mip[11] & mie[11];
    assign w_pend_msi = w_mip[3]  & mie[3];
    assign w_pend_mti = w_mip[7]  & mie[7];
    assign w_irq_take = mstatus[c_MSTATUS_MIE] & (w_pend_mei | w_pend_msi | w_pend_mti);

    assign w_irq_code = w_pend_mei ? c_MEI_CODE :
                        w_pend_msi ? c_MSI_CODE : c_MTI_CODE;

`ifdef PRIV_VECTORED_INT_EN
    assign w_irq_target = (mtvec[1:0] == 2'b01) ? (trap_base(mtvec) + (w_irq_code << 2))
                                                : trap_base(mtvec);
`else
    assign w_irq_target = trap_base(mtvec);
`endif

    assign w_unused = &{1'b0, mie, mtvec[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (exception) begin
                    w_state_next = TRAP;
                end else if (mret) begin
                    w_state_next = RET;
                end else if (w_irq_take) begin
                    w_state_next = TRAP;
                end
            end
            TRAP:     w_state_next = REDIRECT;
            RET:      w_state_next = REDIRECT;
            REDIRECT: if (pipe_ready) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Trap context is captured only on the IDLE decision so it stays stable
    // through the CSR update and the redirect handshake.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mip_rup <= 1'b0;
            r_cause   <= 32'd0;
            r_epc     <= 32'd0;
            r_tval    <= 32'd0;
            r_target  <= 32'd0;
        end else begin
            r_mip_rup <= 1'b1;
            if (r_state == IDLE) begin
                if (exception) begin
                    r_cause  <= {28'd0, ex_cause};
                    r_epc    <= commit_pc;
                    r_tval   <= ex_tval;
                    r_target <= trap_base(mtvec);
                end else if (mret) begin
                    r_target <= mepc;
                end else if (w_irq_take) begin
                    r_cause  <= {1'b1, w_irq_code[30:0]};
                    r_epc    <= commit_pc;
                    r_tval   <= 32'd0;
                    r_target <= w_irq_target;
                end
            end
        end
    end

    always_comb begin
        mcause_rup   = 1'b0;
        mepc_rup     = 1'b0;
        mtval_rup    = 1'b0;
        mstatus_rup  = 1'b0;
        mstatus_next = 32'd0;
        redirect     = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            TRAP: begin
                mcause_rup   = 1'b1;
                mepc_rup     = 1'b1;
                mtval_rup    = 1'b1;
                mstatus_rup  = 1'b1;
                mstatus_next = mstatus;
                mstatus_next[c_MSTATUS_MPIE] = mstatus[c_MSTATUS_MIE];
                mstatus_next[c_MSTATUS_MIE]  = 1'b0;
            end
            RET: begin
                mstatus_rup  = 1'b1;
                mstatus_next = mstatus;
                mstatus_next[c_MSTATUS_MIE]  = mstatus[c_MSTATUS_MPIE];
                mstatus_next[c_MSTATUS_MPIE] = 1'b1;
            end
            REDIRECT: redirect = 1'b1;
            default: ;
        endcase
    end

    assign mip_rup     = r_mip_rup;
    assign mip_next    = w_mip;
    assign mcause_next = r_cause;
    assign mepc_next   = r_epc;
    assign mtval_next  = r_tval;
    assign redirect_pc = r_target;

endmodule

`default_nettype wire

// File: tb/tb_priv_1_11_trap_ctrl.sv
// ============================================================================
// Module      : tb_priv_1_11_trap_ctrl
// Description : Directed self-checking bench for priv_1_11_trap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priv_1_11_trap_ctrl;

    localparam int c_STAGES = 2;

    logic        CLK;
    logic        nRST;
    logic        ext_int, timer_int, soft_int;
    logic        exception;
    logic [3:0]  ex_cause;
    logic [31:0] commit_pc, ex_tval;
    logic        mret, pipe_ready;
    logic [31:0] mstatus, mie, mtvec, mepc;
    logic        mip_rup, mcause_rup, mepc_rup, mtval_rup, mstatus_rup;
    logic [31:0] mip_next, mcause_next, mepc_next, mtval_next, mstatus_next;
    logic        redirect, busy;
    logic [31:0] redirect_pc;

    int n_total = 0;
    int n_pass  = 0;
    int n_wait;

    priv_1_11_trap_ctrl #(.IRQ_SYNC_STAGES(c_STAGES)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .ext_int(ext_int), .timer_int(timer_int), .soft_int(soft_int),
        .exception(exception), .ex_cause(ex_cause), .commit_pc(commit_pc), .ex_tval(ex_tval),
        .mret(mret), .pipe_ready(pipe_ready),
        .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc),
        .mip_rup(mip_rup), .mcause_rup(mcause_rup), .mepc_rup(mepc_rup),
        .mtval_rup(mtval_rup), .mstatus_rup(mstatus_rup),
        .mip_next(mip_next), .mcause_next(mcause_next), .mepc_next(mepc_next),
        .mtval_next(mtval_next), .mstatus_next(mstatus_next),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_trap(output int n);
        n = 0;
        while (!mcause_rup && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        nRST = 1'b0;
        {ext_int, timer_int, soft_int, exception, mret} = '0;
        ex_cause = 4'd0; commit_pc = 32'd0; ex_tval = 32'd0;
        pipe_ready = 1'b1;
        mstatus = 32'd0; mie = 32'd0; mtvec = 32'd0; mepc = 32'd0;

        #12;
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mip_rup", {31'd0, mip_rup}, 32'd0);
        check("rst_strobes", {28'd0, mcause_rup, mepc_rup, mtval_rup, mstatus_rup}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_mstatus_next", mstatus_next, 32'd0);

        @(posedge CLK); #1;
        nRST = 1'b1;
        tick();
        check("mip_rup_after_rst", {31'd0, mip_rup}, 32'd1);

        // Exception trap
        mstatus = 32'h8; mtvec = 32'h800;
        exception = 1'b1; ex_cause = 4'd2; commit_pc = 32'h100; ex_tval = 32'hDEAD;
        tick();
        exception = 1'b0;
        check("exc_strobes", {28'd0, mcause_rup, mepc_rup, mtval_rup, mstatus_rup}, 32'hF);
        check("exc_mcause", mcause_next, 32'h2);
        check("exc_mepc", mepc_next, 32'h100);
        check("exc_mtval", mtval_next, 32'hDEAD);
        check("exc_mstatus", mstatus_next, 32'h80);
        check("exc_redirect_early", {31'd0, redirect}, 32'd0);
        tick();
        check("exc_redirect", {31'd0, redirect}, 32'd1);
        check("exc_redirect_pc", redirect_pc, 32'h800);
        tick();
        check("exc_idle", {31'd0, busy}, 32'd0);

        // All three interrupts: MEI wins
        mie = 32'h888; commit_pc = 32'h444;
        {ext_int, timer_int, soft_int} = 3'b111;
        wait_trap(n_wait);
        check("irq_latency", n_wait, c_STAGES + 1);
        check("irq_mip_next", mip_next, 32'h888);
        check("irq_mcause", mcause_next, 32'h8000000B);
        check("irq_mtval", mtval_next, 32'h0);
        check("irq_mepc", mepc_next, 32'h444);
        mstatus = 32'h0;
        {ext_int, timer_int, soft_int} = 3'b000;
        tick();
        check("irq_redirect_pc", redirect_pc, 32'h800);
        tick();
        repeat (4) tick();

        // Software beats timer
        mstatus = 32'h8;
        {timer_int, soft_int} = 2'b11;
        wait_trap(n_wait);
        check("msi_mcause", mcause_next, 32'h80000003);
        mstatus = 32'h0;
        {timer_int, soft_int} = 2'b00;
        tick(); tick();
        repeat (4) tick();

        // Timer with vectored mtvec
        mstatus = 32'h8; mie = 32'h80; mtvec = 32'h801;
        timer_int = 1'b1;
        wait_trap(n_wait);
        check("mti_mcause", mcause_next, 32'h80000007);
        mstatus = 32'h0; timer_int = 1'b0;
        tick();
`ifdef PRIV_VECTORED_INT_EN
        check("mti_vec_pc", redirect_pc, 32'h81C);
`else
        check("mti_vec_pc", redirect_pc, 32'h800);
`endif
        tick();
        repeat (4) tick();

        // MRET
        mtvec = 32'h800; mstatus = 32'h80; mepc = 32'h240;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("ret_strobes", {28'd0, mcause_rup, mepc_rup, mtval_rup, mstatus_rup}, 32'h1);
        check("ret_mstatus", mstatus_next, 32'h88);
        tick();
        check("ret_redirect_pc", redirect_pc, 32'h240);
        tick();

        // Exception + MRET together, stalled redirect, dropped second exception
        mstatus = 32'h0; pipe_ready = 1'b0;
        exception = 1'b1; mret = 1'b1; ex_cause = 4'd2; commit_pc = 32'h300; ex_tval = 32'h11;
        tick();
        exception = 1'b0; mret = 1'b0;
        check("both_trap", {31'd0, mcause_rup}, 32'd1);
        check("both_mepc", mepc_next, 32'h300);
        exception = 1'b1; ex_cause = 4'd5;
        tick();
        exception = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_redirect", {31'd0, redirect}, 32'd1);
            check("hold_pc", redirect_pc, 32'h800);
            tick();
        end
        pipe_ready = 1'b1;
        check("hold_release", {31'd0, redirect}, 32'd1);
        tick();
        check("after_idle", {31'd0, busy}, 32'd0);
        check("dropped_cause", mcause_next, 32'h2);
        tick();
        check("no_retrap", {31'd0, mcause_rup}, 32'd0);

        // Reset during REDIRECT
        pipe_ready = 1'b0;
        exception = 1'b1; ex_cause = 4'd4;
        tick();
        exception = 1'b0;
        tick();
        check("pre_rst_redirect", {31'd0, redirect}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("midrst_redirect", {31'd0, redirect}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pc", redirect_pc, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("post_rst_mip_rup", {31'd0, mip_rup}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
